// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo disparity search.
// Contents: pixel/word/SAD widths, the search FSM state type and the
// pix() helper that extracts pixel c from a packed row word (pixel c
// occupies bits [8c+7:8c]).
package stereo_pkg;

    localparam int PIX_W      = 8;
    localparam int BLOCK_SIZE = 6;
    localparam int WORD_W     = 48;
    localparam int SAD_W      = 14;
    localparam int ROW_W      = 11;
    localparam int DISP_W     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } search_state_t;

    // Word is sized for a full right-strip row; left rows are zero-extended.
    function automatic logic [PIX_W-1:0] pix(input logic [2*WORD_W-1:0] word,
                                             input int c);
        return word[c*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/block_disparity_search_if.sv
// Block/strip input bundle and result outputs of block_disparity_search.
// Handshake: a block is taken on a rising clock edge where valid_in and
// ready_out are both high; valid_in seen while ready_out is low is
// dropped, not queued. valid_out is a one-cycle pulse marking best_disp
// and best_sad as a fresh result; those two hold until the next pulse.
//   valid_in, left_block[6], right_front[6], right_back[6] : master -> slave
//   ready_out, valid_out, best_disp, best_sad               : slave -> master
interface block_disparity_search_if;
    import stereo_pkg::*;

    logic                   valid_in;
    logic [WORD_W-1:0]      left_block  [BLOCK_SIZE];
    logic [WORD_W-1:0]      right_front [BLOCK_SIZE];
    logic [WORD_W-1:0]      right_back  [BLOCK_SIZE];
    logic                   ready_out;
    logic                   valid_out;
    logic [DISP_W-1:0]      best_disp;
    logic [SAD_W-1:0]       best_sad;

    modport slave (
        input  valid_in, left_block, right_front, right_back,
        output ready_out, valid_out, best_disp, best_sad
    );

    modport master (
        output valid_in, left_block, right_front, right_back,
        input  ready_out, valid_out, best_disp, best_sad
    );

endinterface

// File: rtl/block_disparity_search_row_sad.sv
// row_sad: combinational SAD of one 6-pixel left row against the right
// strip row shifted by disparity disp_i.
// Ports:
//   left_row_i  [47:0] left row, pixel c at [8c+7:8c]
//   right_row_i [95:0] {right_back, right_front} row, strip pixel k at [8k+7:8k]
//   disp_i      [2:0]  candidate disparity (0..6)
//   sum_o       [10:0] sum of the six absolute differences
module row_sad
    import stereo_pkg::*;
(
    input  logic [WORD_W-1:0]   left_row_i,
    input  logic [2*WORD_W-1:0] right_row_i,
    input  logic [DISP_W-1:0]   disp_i,
    output logic [ROW_W-1:0]    sum_o
);

    logic [PIX_W-1:0] ad [BLOCK_SIZE];
    logic [PIX_W:0]   s01, s23, s45;
    logic [PIX_W+1:0] s0123;

    always_comb begin
        logic [PIX_W-1:0] a;
        logic [PIX_W-1:0] b;
        for (int c = 0; c < BLOCK_SIZE; c++) begin
            a     = pix({{WORD_W{1'b0}}, left_row_i}, c);
            b     = pix(right_row_i, c + int'(disp_i));
            ad[c] = (a >= b) ? (a - b) : (b - a);
        end
    end

    // Balanced tree: 3 x 9-bit pair sums, one 10-bit sum, final 11-bit.
    always_comb begin
        s01   = {1'b0, ad[0]} + {1'b0, ad[1]};
        s23   = {1'b0, ad[2]} + {1'b0, ad[3]};
        s45   = {1'b0, ad[4]} + {1'b0, ad[5]};
        s0123 = {1'b0, s01} + {1'b0, s23};
        sum_o = {1'b0, s0123} + {2'b00, s45};
    end

endmodule

// File: rtl/block_disparity_search.sv
// block_disparity_search: captures one 6x6 left block and a 12-pixel-wide
// right strip, evaluates SAD for disparities 0..MAX_DISP one row per cycle
// and reports the lowest-SAD disparity (lowest disparity wins ties).
// Ports:
//   clk_in       clock
//   rst_in       asynchronous active-high reset
//   bus          block_disparity_search_if.slave (inputs, handshake, results)
//   dbg_state_o  current FSM state
module block_disparity_search
    import stereo_pkg::*;
#(
    parameter int MAX_DISP = 6
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    block_disparity_search_if.slave   bus,
    output search_state_t             dbg_state_o
);

    search_state_t      state_q, state_d;
    logic [WORD_W-1:0]  left_q  [BLOCK_SIZE];
    logic [WORD_W-1:0]  front_q [BLOCK_SIZE];
    logic [WORD_W-1:0]  back_q  [BLOCK_SIZE];
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic [2:0]         row_q, row_d;
    logic [SAD_W-1:0]   acc_q, acc_d;
    logic [SAD_W-1:0]   run_sad_q, run_sad_d;
    logic [DISP_W-1:0]  run_disp_q, run_disp_d;
    logic [SAD_W-1:0]   out_sad_q, out_sad_d;
    logic [DISP_W-1:0]  out_disp_q, out_disp_d;

    logic               accept;
    logic [ROW_W-1:0]   row_sum;
    logic [SAD_W-1:0]   total;
    logic               better;
    logic               last_row;
    logic               last_disp;

    row_sad u_row_sad (
        .left_row_i  (left_q[row_q]),
        .right_row_i ({back_q[row_q], front_q[row_q]}),
        .disp_i      (disp_q),
        .sum_o       (row_sum)
    );

    assign total     = acc_q + {{(SAD_W-ROW_W){1'b0}}, row_sum};
    assign better    = total < run_sad_q;
    assign last_row  = row_q == 3'(BLOCK_SIZE - 1);
    assign last_disp = disp_q == DISP_W'(MAX_DISP);

    always_comb begin
        state_d    = state_q;
        disp_d     = disp_q;
        row_d      = row_q;
        acc_d      = acc_q;
        run_sad_d  = run_sad_q;
        run_disp_d = run_disp_q;
        out_sad_d  = out_sad_q;
        out_disp_d = out_disp_q;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    accept     = 1'b1;
                    disp_d     = '0;
                    row_d      = '0;
                    acc_d      = '0;
                    run_sad_d  = '1;
                    run_disp_d = '0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                if (!last_row) begin
                    acc_d = total;
                    row_d = row_q + 3'd1;
                end else begin
                    acc_d = '0;
                    row_d = '0;
                    if (better) begin
                        run_sad_d  = total;
                        run_disp_d = disp_q;
                    end
                    if (last_disp) begin
                        // Publish the final winner, including this last candidate.
                        out_sad_d  = better ? total  : run_sad_q;
                        out_disp_d = better ? disp_q : run_disp_q;
                        state_d    = DONE;
                    end else begin
                        disp_d = disp_q + DISP_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            disp_q     <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            run_sad_q  <= '0;
            run_disp_q <= '0;
            out_sad_q  <= '0;
            out_disp_q <= '0;
        end else begin
            state_q    <= state_d;
            disp_q     <= disp_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            run_sad_q  <= run_sad_d;
            run_disp_q <= run_disp_d;
            out_sad_q  <= out_sad_d;
            out_disp_q <= out_disp_d;
        end
    end

    // Capturing the words lets the fetcher refill while the search runs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < BLOCK_SIZE; r++) begin
                left_q[r]  <= '0;
                front_q[r] <= '0;
                back_q[r]  <= '0;
            end
        end else if (accept) begin
            left_q  <= bus.left_block;
            front_q <= bus.right_front;
            back_q  <= bus.right_back;
        end
    end

    assign bus.ready_out = (state_q == IDLE);
    assign bus.valid_out = (state_q == DONE);
    assign bus.best_disp = out_disp_q;
    assign bus.best_sad  = out_sad_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_block_disparity_search.sv
module tb_block_disparity_search;
  import stereo_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  block_disparity_search_if bus6 ();
  block_disparity_search_if bus2 ();

  logic [47:0] lw [6];
  logic [47:0] fw [6];
  logic [47:0] bw [6];
  logic v6 = 1'b0;
  logic v2 = 1'b0;

  assign bus6.valid_in    = v6;
  assign bus6.left_block  = lw;
  assign bus6.right_front = fw;
  assign bus6.right_back  = bw;
  assign bus2.valid_in    = v2;
  assign bus2.left_block  = lw;
  assign bus2.right_front = fw;
  assign bus2.right_back  = bw;

  search_state_t st6, st2;

  block_disparity_search #(.MAX_DISP(6)) dut6 (
    .clk_in(clk), .rst_in(rst), .bus(bus6), .dbg_state_o(st6));
  block_disparity_search #(.MAX_DISP(2)) dut2 (
    .clk_in(clk), .rst_in(rst), .bus(bus2), .dbg_state_o(st2));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [16:0] exp_q[$];

  logic [7:0] L [6][6];
  logic [7:0] R [6][12];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int g_vo(input int w);
    return w != 0 ? int'(bus2.valid_out) : int'(bus6.valid_out);
  endfunction
  function automatic int g_rdy(input int w);
    return w != 0 ? int'(bus2.ready_out) : int'(bus6.ready_out);
  endfunction
  function automatic int g_bd(input int w);
    return w != 0 ? int'(bus2.best_disp) : int'(bus6.best_disp);
  endfunction
  function automatic int g_bs(input int w);
    return w != 0 ? int'(bus2.best_sad) : int'(bus6.best_sad);
  endfunction

  // Reference: exhaustive SAD over candidate disparities, strict-less keeps lowest d.
  function automatic void model(input int maxd, output int bd, output int bs);
    int s;
    int a;
    int b;
    bs = 1 << 30;
    bd = 0;
    for (int d = 0; d <= maxd; d++) begin
      s = 0;
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          a = int'(L[r][c]);
          b = int'(R[r][c+d]);
          s += (a > b) ? a - b : b - a;
        end
      if (s < bs) begin
        bs = s;
        bd = d;
      end
    end
  endfunction

  // kind 0: identical strip, 1: ramp shifted by 'shift', 2: tie (0 vs FF), 3: random
  task automatic fill_pattern(input int kind, input int shift);
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 12; k++) begin
        case (kind)
          0: R[r][k] = (k < 6) ? 8'h10 : 8'hFF;
          1: R[r][k] = 8'hFF;
          2: R[r][k] = 8'hFF;
          default: R[r][k] = 8'($urandom_range(0, 255));
        endcase
      end
      for (int c = 0; c < 6; c++) begin
        case (kind)
          0: L[r][c] = 8'h10;
          1: begin
            L[r][c] = 8'(16 * r + c + 1);
            R[r][c+shift] = L[r][c];
          end
          2: L[r][c] = 8'h00;
          default: L[r][c] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic pack();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        lw[r][8*c +: 8] = L[r][c];
        fw[r][8*c +: 8] = R[r][c];
        bw[r][8*c +: 8] = R[r][c+6];
      end
  endtask

  // ---------------- driver ----------------
  task automatic run_block(input int w, input int exp_d, input int exp_s, input string name);
    int lat_exp;
    int k;
    bit seen;
    int held_d;
    logic [16:0] e;
    lat_exp = (w != 0) ? 19 : 43;
    check({name, "_ready_idle"}, g_rdy(w), 1);
    @(negedge clk);
    if (w != 0) v2 = 1'b1; else v6 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    v6 = 1'b0;
    exp_q.push_back({3'(exp_d), 14'(exp_s)});
    // Inputs only need to be stable in the accept cycle.
    fill_pattern(3, 0);
    pack();
    check({name, "_ready_busy"}, g_rdy(w), 0);
    k = 1;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (g_vo(w) != 0) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        k++;
      end
    end
    check({name, "_latency"}, seen ? k : -1, lat_exp);
    e = exp_q.pop_front();
    if (seen) begin
      check({name, "_disp"}, g_bd(w), int'(e[16:14]));
      check({name, "_sad"}, g_bs(w), int'(e[13:0]));
    end
    held_d = g_bd(w);
    @(posedge clk); #1;
    check({name, "_valid_pulse_end"}, g_vo(w), 0);
    check({name, "_ready_after"}, g_rdy(w), 1);
    check({name, "_hold_disp"}, g_bd(w), held_d);
  endtask

  typedef struct {
    int    kind;
    int    shift;
    int    exp_d;
    int    exp_s;
    string name;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int md;
    int ms;
    int k;
    int cnt;

    vecs[0] = '{kind: 0, shift: 0, exp_d: 0, exp_s: 0,    name: "identical"};
    vecs[1] = '{kind: 1, shift: 3, exp_d: 3, exp_s: 0,    name: "shift3"};
    vecs[2] = '{kind: 2, shift: 0, exp_d: 0, exp_s: 9180, name: "tie"};

    fill_pattern(2, 0);
    pack();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid6", g_vo(0), 0);
    check("rst_disp6", g_bd(0), 0);
    check("rst_sad6", g_bs(0), 0);
    check("rst_valid2", g_vo(1), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready6", g_rdy(0), 1);
    check("rst_ready2", g_rdy(1), 1);
    check("rst_state6", int'(st6), int'(IDLE));

    // table-driven directed vectors
    for (int i = 0; i < 3; i++) begin
      fill_pattern(vecs[i].kind, vecs[i].shift);
      pack();
      run_block(0, vecs[i].exp_d, vecs[i].exp_s, vecs[i].name);
    end

    // random blocks against the reference model
    for (int i = 0; i < 5; i++) begin
      fill_pattern(3, 0);
      pack();
      model(6, md, ms);
      run_block(0, md, ms, "rand6");
    end

    // MAX_DISP=2 build
    fill_pattern(1, 1);
    pack();
    run_block(1, 1, 0, "d2_shift1");
    fill_pattern(1, 5);
    pack();
    model(2, md, ms);
    run_block(1, md, ms, "d2_shift5");
    for (int i = 0; i < 3; i++) begin
      fill_pattern(3, 0);
      pack();
      model(2, md, ms);
      run_block(1, md, ms, "rand2");
    end

    // busy rejection: second valid at T+5 must be dropped
    fill_pattern(1, 3);
    pack();
    @(negedge clk);
    v6 = 1'b1;
    @(posedge clk); #1;
    v6 = 1'b0;
    k = 1;
    cnt = 0;
    while (k <= 43) begin
      if (g_vo(0) != 0) begin
        cnt++;
        check("busy_first_disp", g_bd(0), 3);
        check("busy_first_sad", g_bs(0), 0);
      end
      if (k == 5) begin
        fill_pattern(2, 0);
        pack();
        check("busy_ready_low", g_rdy(0), 0);
        v6 = 1'b1;
      end
      @(posedge clk); #1;
      v6 = 1'b0;
      k++;
    end
    check("busy_one_pulse", cnt, 1);
    check("busy_t44_valid_low", g_vo(0), 0);
    // tie data is still on the bus: re-present it at T+44
    run_block(0, 0, 9180, "busy_rerun");

    // mid-search reset at T+20
    fill_pattern(1, 3);
    pack();
    @(negedge clk);
    v6 = 1'b1;
    @(posedge clk); #1;
    v6 = 1'b0;
    for (k = 1; k < 20; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", g_vo(0), 0);
    check("midrst_disp", g_bd(0), 0);
    check("midrst_sad", g_bs(0), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready", g_rdy(0), 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (g_vo(0) != 0) cnt++;
    end
    check("midrst_no_valid", cnt, 0);
    fill_pattern(1, 3);
    pack();
    run_block(0, 3, 0, "post_reset_shift3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_disparity_search.md
# block_disparity_search

Consumes one 6×6 left-image block and a 12-pixel-wide right-image search strip from the stereo buffer fetcher (its `left_*_buffer` / `right_front_buffer` / `right_back_buffer` outputs plus `valid_out`). Computes the sum of absolute differences (SAD) for every candidate disparity and reports the best disparity and its SAD. It sits directly downstream of the buffer-fetch stage and upstream of the depth-map writer. Inputs are captured on acceptance, so the fetcher can refill its buffers while the search runs.

## Interface
- `BLOCK_SIZE`, 6: block rows/cols; fixed at 6, since one 48-bit word holds 6 pixels.
- `PIX_W`, 8: bits per pixel; fixed at 8.
- `MAX_DISP`, 6: largest disparity tested, legal range 1..6; candidates are 0..MAX_DISP.
- `clk_in`  in  1  sole clock.
- `rst_in`  in  1  reset, asynchronous and active-high.
- `valid_in`  in  1  block and strip words are valid this cycle.
- `left_block`  in  [47:0] ×6  left block rows; pixel c is at bits [8c+7:8c].
- `right_front`  in  [47:0] ×6  right strip columns 0..5, per row.
- `right_back`  in  [47:0] ×6  right strip columns 6..11, per row.
- `ready_out`  out  1  high when the block can accept `valid_in`.
- `valid_out`  out  1  one-cycle pulse; the result outputs are valid.
- `best_disp`  out  3  winning disparity, 0..MAX_DISP.
- `best_sad`  out  14  SAD of the winner; maximum value 36×255 = 9180.

## Operation
- Strip pixel R[r][k], for k = 0..11: k<6 is `right_front[r]` pixel k; k≥6 is `right_back[r]` pixel k−6.
- Candidate SAD(d) = Σ over r,c in 0..5 of |L[r][c] − R[r][c+d]|.
- All arithmetic is unsigned.
  - Absolute difference: 8 bits.
  - Row sum: 11 bits.
  - Accumulator: 14 bits, which cannot overflow.
- States: IDLE, ACCUM, DONE.
- **IDLE**
  - `ready_out`=1.
  - On `valid_in`: latch all 18 input words, set d=0, row=0, acc=0, best_sad=all-ones (internal running copy), then go to ACCUM.
- **ACCUM**, one (d,row) pair per cycle:
  - row<5: acc += rowsad(d,row); row++.
  - row==5:
    - total = acc + rowsad.
    - If total < running best (strict), update the best and best_disp. Ties keep the lower disparity.
    - Then acc=0, row=0.
    - If d==MAX_DISP go to DONE, else d++.
- **DONE**
  - `valid_out`=1.
  - `best_disp`/`best_sad` driven from the running best.
  - Unconditionally return to IDLE next cycle.
- `valid_in` outside IDLE is ignored; it is neither queued nor counted.
- `best_disp`/`best_sad` hold their last result until the next DONE.
- **Reset, including mid-ACCUM**, takes effect immediately:
  - State returns to IDLE.
  - `valid_out`=0, `best_disp`=0, `best_sad`=0.
  - Counters and accumulator are cleared.
  - `ready_out`=1 once reset deasserts.
  - A partial search is discarded and no `valid_out` is produced for it.

## Timing
- Accept at edge T, when `valid_in`=1 and `ready_out`=1.
- ACCUM occupies cycles T+1 .. T+6·(MAX_DISP+1).
- `valid_out` is high in the single cycle T+6·(MAX_DISP+1)+1:
  - 43 cycles after accept for MAX_DISP=6.
  - 19 cycles after accept for MAX_DISP=2.
- `ready_out` is low from T+1 through the DONE cycle and high again the cycle after DONE.
- Maximum throughput is one block per 6·(MAX_DISP+1)+2 cycles.
- The input words need only be stable in the accept cycle.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `stereo_pkg`:
  - `PIX_W`, `BLOCK_SIZE`, `WORD_W`=48, `SAD_W`=14.
  - Typedef `search_state_t` {IDLE, ACCUM, DONE}.
  - Function `pix(word, c)` for pixel extraction.
- Sub-module `row_sad`:
  - Purely combinational.
  - Inputs: one 48-bit left row, one 96-bit right row (back concatenated above front), and d.
  - Performs 6 abs-diffs feeding an adder tree, and outputs an 11-bit row sum.
- Top level: input capture registers, the FSM, the d/row counters, the accumulator and the best tracker.

## Test plan
- Identical strip: `right_front` = `left_block`, `right_back` all 0xFF, L all 0x10 → `best_disp`=0, `best_sad`=0, `valid_out` pulse at T+43, `ready_out` high at T+44.
- Shift by 3: R[r][c+3] = L[r][c] using distinct ramp values (L[r][c]=16r+c+1), other strip pixels 0xFF → `best_disp`=3, `best_sad`=0.
- Tie case: L all 0x00, R all 0xFF → every SAD is 9180 → `best_disp`=0, `best_sad`=9180.
- Busy rejection:
  - Stimulus: a second `valid_in` at T+5 with different data.
  - Response: `ready_out`=0 then, the first result is unaffected, and exactly one `valid_out` occurs.
  - Follow-up: re-presenting the data at T+44 is accepted and yields its own result.
- Mid-search reset:
  - Stimulus: `rst_in` pulsed at T+20.
  - Response: outputs are zero immediately, no `valid_out`, `ready_out`=1 after release.
  - Follow-up: a new shift-by-3 block gives `best_disp`=3.
- MAX_DISP=2 build:
  - Stimulus: shift-by-1 data.
  - Response: `best_disp`=1, `valid_out` at T+19.
  - Stimulus: shift-by-5 data.
  - Response: `best_disp` is the minimum over d=0..2 computed by the reference model.
